// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment front-panel driver: blank pattern,
// hex segment table ({g,f,e,d,c,b,a}, active-high) and a lookup helper.
package seg7_pkg;

    localparam logic [6:0] SEG7_BLANK = 7'b0000000;

    // Entry k is the pattern for hex digit k (entry 0 is the rightmost element).
    localparam logic [15:0][6:0] SEG7_TABLE = {
        7'b1110001, 7'b1111001, 7'b1011110, 7'b0111001,
        7'b1111100, 7'b1110111, 7'b1101111, 7'b1111111,
        7'b0000111, 7'b1111101, 7'b1101101, 7'b1100110,
        7'b1001111, 7'b1011011, 7'b0000110, 7'b0111111
    };

    function automatic logic [6:0] seg7_hex(input logic [3:0] nib);
        return SEG7_TABLE[nib];
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-high seven-segment pattern.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    assign o_seg = seg7_hex(i_nibble);

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed seven-segment scan driver with double-buffered value,
// blank/dp masks and leading-zero suppression; all pin outputs are registered.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic                    lz_blank,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    pending,
    output logic                    frame_tick
);

    localparam int DIV_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic POL = (ACTIVE_LOW != 0);

    logic [DIV_W-1:0]        r_div_cnt;
    logic [IDX_W-1:0]        r_idx;
    logic [4*NUM_DIGITS-1:0] r_shd_value, r_act_value;
    logic [NUM_DIGITS-1:0]   r_shd_blank, r_act_blank;
    logic [NUM_DIGITS-1:0]   r_shd_dp, r_act_dp;
    logic                    r_shd_lz, r_act_lz;

    logic                    w_tc;
    logic                    w_frame;
    logic                    w_zero_run;
    logic [NUM_DIGITS-1:0]   w_lz_dark;
    logic [3:0]              w_nibble;
    logic                    w_dark;
    logic                    w_dp_bit;
    logic [NUM_DIGITS-1:0]   w_an_ah;
    logic [6:0]              w_dec;
    logic [6:0]              w_seg_ah;

    assign w_tc    = (r_div_cnt == DIV_LAST);
    assign w_frame = w_tc && (r_idx == IDX_LAST);

    // A digit is lz-dark when it and every digit above it are zero; digit 0 never is.
    always_comb begin
        w_zero_run = 1'b1;
        w_lz_dark  = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            w_zero_run   = w_zero_run & (r_act_value[4*i +: 4] == 4'h0);
            w_lz_dark[i] = r_act_lz & w_zero_run;
        end
    end

    always_comb begin
        w_nibble = 4'h0;
        w_dark   = 1'b0;
        w_dp_bit = 1'b0;
        w_an_ah  = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_nibble   = r_act_value[4*i +: 4];
                w_dark     = r_act_blank[i] | w_lz_dark[i];
                w_dp_bit   = r_act_dp[i];
                w_an_ah[i] = 1'b1;
            end
        end
    end

    seg7_hex_decode u_decode (
        .i_nibble (w_nibble),
        .o_seg    (w_dec)
    );

    assign w_seg_ah = w_dark ? SEG7_BLANK : w_dec;

    // Load handshake: load is a single-cycle strobe with no back-pressure. It
    // fills the shadow and raises pending; the shadow is promoted at the next
    // frame boundary. A load landing on the boundary itself bypasses the shadow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div_cnt   <= '0;
            r_idx       <= '0;
            r_shd_value <= '0;
            r_shd_blank <= '0;
            r_shd_dp    <= '0;
            r_shd_lz    <= 1'b0;
            r_act_value <= '0;
            r_act_blank <= '0;
            r_act_dp    <= '0;
            r_act_lz    <= 1'b0;
            pending     <= 1'b0;
            frame_tick  <= 1'b0;
            seg         <= {7{POL}};
            dp          <= POL;
            an          <= {NUM_DIGITS{POL}};
        end else begin
            r_div_cnt  <= w_tc ? '0 : r_div_cnt + DIV_W'(1);
            if (w_tc) begin
                r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
            end
            frame_tick <= w_frame;

            if (load && w_frame) begin
                r_act_value <= value;
                r_act_blank <= blank_mask;
                r_act_dp    <= dp_mask;
                r_act_lz    <= lz_blank;
                pending     <= 1'b0;
            end else if (load) begin
                r_shd_value <= value;
                r_shd_blank <= blank_mask;
                r_shd_dp    <= dp_mask;
                r_shd_lz    <= lz_blank;
                pending     <= 1'b1;
            end else if (w_frame && pending) begin
                r_act_value <= r_shd_value;
                r_act_blank <= r_shd_blank;
                r_act_dp    <= r_shd_dp;
                r_act_lz    <= r_shd_lz;
                pending     <= 1'b0;
            end

            seg <= {7{POL}} ^ w_seg_ah;
            dp  <= POL ^ w_dp_bit;
            an  <= {NUM_DIGITS{POL}} ^ w_an_ah;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver (4 digits, divide-by-4, active-low): expected
// per-cycle {an,seg,dp} words are queued at load time and popped while scanning.
module tb_seg7_scan_driver;

    localparam int N   = 4;
    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  blank_mask = '0;
    logic [3:0]  dp_mask = '0;
    logic        lz_blank = 1'b0;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        pending;
    logic        frame_tick;

    int checks   = 0;
    int failures = 0;

    logic [11:0] exp_q[$];

    logic [15:0] cur_v  = '0;
    logic [3:0]  cur_bm = '0;
    logic [3:0]  cur_dm = '0;
    logic        cur_lz = 1'b0;

    logic [6:0] hex_tbl [16] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
        7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
    };

    seg7_scan_driver #(
        .NUM_DIGITS  (N),
        .REFRESH_DIV (DIV),
        .ACTIVE_LOW  (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .value      (value),
        .blank_mask (blank_mask),
        .dp_mask    (dp_mask),
        .lz_blank   (lz_blank),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .pending    (pending),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // Pin-level {an, seg, dp} expected while digit d is enabled.
    function automatic logic [11:0] exp_word(input logic [15:0] v, input logic [3:0] bm,
                                             input logic [3:0] dm, input logic lz, input int d);
        logic [15:0] upper;
        logic        dark;
        logic [6:0]  s;
        logic [3:0]  a;
        upper = v >> (4 * d);
        dark  = bm[d] || (lz && d != 0 && upper == 16'h0);
        s     = dark ? 7'b0000000 : hex_tbl[v[4*d +: 4]];
        a     = 4'b0001 << d;
        return {~a, ~s, ~dm[d]};
    endfunction

    task automatic push_frame(input int first, input int last);
        for (int c = first; c <= last; c++) begin
            exp_q.push_back(exp_word(cur_v, cur_bm, cur_dm, cur_lz, c / DIV));
        end
    endtask

    // Samples cycles first..last of a frame; cycle 15 ends on the next boundary.
    task automatic run_frame(input string tag, input int first, input int last, input logic pend);
        logic [11:0] exp;
        logic        exp_pend;
        for (int c = first; c <= last; c++) begin
            @(negedge clk);
            load       = 1'b0;
            value      = 16'($urandom_range(0, 65535));
            blank_mask = 4'($urandom_range(0, 15));
            dp_mask    = 4'($urandom_range(0, 15));
            lz_blank   = 1'($urandom_range(0, 1));
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL %s cycle %0d: scoreboard empty, got an=%b seg=%b dp=%b", tag, c, an, seg, dp);
            end else begin
                exp = exp_q.pop_front();
                if ({an, seg, dp} !== exp) begin
                    failures++;
                    $display("FAIL %s cycle %0d: got an=%b seg=%b dp=%b expected an=%b seg=%b dp=%b",
                             tag, c, an, seg, dp, exp[11:8], exp[7:1], exp[0]);
                end
            end
            checks++;
            if (frame_tick !== (c == 15)) begin
                failures++;
                $display("FAIL %s frame_tick cycle %0d: got %b expected %b", tag, c, frame_tick, (c == 15));
            end
            exp_pend = (c == 15) ? 1'b0 : pend;
            checks++;
            if (pending !== exp_pend) begin
                failures++;
                $display("FAIL %s pending cycle %0d: got %b expected %b", tag, c, pending, exp_pend);
            end
        end
    endtask

    // Called at a frame_tick negedge: load now, old frame holds, new frame follows.
    task automatic load_and_show(input string tag, input logic [15:0] v, input logic [3:0] bm,
                                 input logic [3:0] dm, input logic lz);
        value = v; blank_mask = bm; dp_mask = dm; lz_blank = lz; load = 1'b1;
        push_frame(0, 15);
        run_frame({tag, "_hold"}, 0, 15, 1'b1);
        cur_v = v; cur_bm = bm; cur_dm = dm; cur_lz = lz;
        push_frame(0, 15);
        run_frame({tag, "_show"}, 0, 15, 1'b0);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        push_frame(0, 15);
        run_frame("post_reset", 0, 15, 1'b0);
        repeat (5) @(negedge clk);
        value = 16'h5555; blank_mask = '0; dp_mask = '0; lz_blank = 1'b0; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        checks++;
        if (pending !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset_pending: got %b expected 1", pending);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({an, seg, dp, pending, frame_tick} !== {4'b1111, 7'b1111111, 1'b1, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_async: got an=%b seg=%b dp=%b pending=%b tick=%b expected 1111 1111111 1 0 0",
                     an, seg, dp, pending, frame_tick);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        push_frame(0, 15);
        run_frame("reset_restart", 0, 15, 1'b0);
    endtask

    task automatic test_load_display();
        load_and_show("val_12AF", 16'h12AF, 4'b0000, 4'b0000, 1'b0);
    endtask

    task automatic test_hex_sweep();
        for (int k = 0; k < 16; k++) begin
            load_and_show($sformatf("hex_%0d", k), 16'(k), 4'b0000, 4'b0000, 1'b0);
        end
    endtask

    task automatic test_lz_blank();
        load_and_show("lz_0040", 16'h0040, 4'b0000, 4'b0000, 1'b1);
        load_and_show("lz_0000", 16'h0000, 4'b0000, 4'b0000, 1'b1);
    endtask

    task automatic test_back_to_back();
        value = 16'h1111; blank_mask = '0; dp_mask = '0; lz_blank = 1'b0; load = 1'b1;
        @(negedge clk);
        value = 16'h2222; load = 1'b1;
        @(negedge clk);
        push_frame(2, 15);
        run_frame("b2b_hold", 2, 15, 1'b1);
        cur_v = 16'h2222; cur_bm = '0; cur_dm = '0; cur_lz = 1'b0;
        push_frame(0, 15);
        run_frame("b2b_show", 0, 15, 1'b0);

        push_frame(0, 14);
        run_frame("pre_boundary", 0, 14, 1'b0);
        value = 16'h3456; blank_mask = '0; dp_mask = '0; lz_blank = 1'b0; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        checks++;
        if ({frame_tick, pending} !== 2'b10) begin
            failures++;
            $display("FAIL boundary_load_tick: got tick=%b pending=%b expected tick=1 pending=0",
                     frame_tick, pending);
        end
        cur_v = 16'h3456;
        push_frame(0, 15);
        run_frame("boundary_show", 0, 15, 1'b0);
    endtask

    task automatic test_dp_blank();
        load_and_show("dp_blank", 16'h1234, 4'b0001, 4'b0100, 1'b0);
    endtask

    initial begin
        test_reset();
        test_load_display();
        test_hex_sweep();
        test_lz_blank();
        test_back_to_back();
        test_dp_blank();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
